// File: rtl/result_collector.sv
// result_collector_pkg: payload carried through the result FIFO.
package result_collector_pkg;

  // One found result: block epoch plus the winning nonce.
  typedef struct packed {
    logic [7:0]  epoch;
    logic [31:0] nonce;
  } result_t;

endpackage : result_collector_pkg

// result_collector
//   Gathers per-core success flags from a bank of lockstep lattice cores,
//   reconstructs each winning nonce as {beat suffix, core index} and queues
//   {epoch, nonce} results in a first-word-fall-through FIFO for the host.
//
// Parameters
//   NUM_CORES   number of lockstep cores, power of two, 2..16
//   FIFO_DEPTH  result FIFO entries, power of two, >= 2
//
// Ports
//   clk            sole clock, rising edge
//   rst            asynchronous active-low reset
//   core_valid     per-core validOut; bit 0 defines a beat
//   core_newblock  per-core newBlockOut (bit 0 sampled on beats)
//   core_success   per-core success flags (sampled on beats)
//   result_valid   FIFO head valid
//   result_ready   host accepts the head
//   result_nonce   head nonce
//   result_epoch   head block epoch
//   overflow       sticky: a success was dropped
//   lockstep_err   sticky: core_valid bits disagreed
//   found_count    results pushed, wraps at 16 bits
module result_collector
  import result_collector_pkg::*;
#(
  parameter int unsigned NUM_CORES  = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CORES-1:0] core_valid,
  input  logic [NUM_CORES-1:0] core_newblock,
  input  logic [NUM_CORES-1:0] core_success,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic [31:0]          result_nonce,
  output logic [7:0]           result_epoch,
  output logic                 overflow,
  output logic                 lockstep_err,
  output logic [15:0]          found_count
);

  localparam int unsigned IDXBITS = $clog2(NUM_CORES);
  localparam int unsigned SUFBITS = 32 - IDXBITS;
  localparam int unsigned PTRW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CNTW    = PTRW + 1;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [SUFBITS-1:0]   suffix_cnt;
  logic [7:0]           epoch_q;

  logic [NUM_CORES-1:0] pend_mask;
  logic [SUFBITS-1:0]   pend_suffix;
  logic [7:0]           pend_epoch;

  result_t              mem [FIFO_DEPTH];
  logic [PTRW-1:0]      wr_ptr;
  logic [PTRW-1:0]      rd_ptr;
  logic [CNTW-1:0]      count;

  logic                 overflow_q;
  logic                 lockstep_q;
  logic [15:0]          found_q;

  // ---------------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------------
  logic                 beat;
  logic                 newblk;
  logic [SUFBITS-1:0]   beat_suffix;
  logic [7:0]           beat_epoch;
  logic                 fifo_full;
  logic                 pop;
  logic                 push;
  logic [NUM_CORES-1:0] low_onehot;
  logic [IDXBITS-1:0]   low_idx;
  logic [NUM_CORES-1:0] mask_after;
  logic                 succ_beat;
  logic                 accept;
  logic                 drop;
  logic                 lock_bad;
  result_t              push_data;
  result_t              head;

  // Beat qualification and the suffix/epoch this beat is tagged with.
  always_comb begin
    beat        = core_valid[0];
    newblk      = beat & core_newblock[0];
    beat_suffix = newblk ? '0 : suffix_cnt;
    beat_epoch  = newblk ? (epoch_q + 8'd1) : epoch_q;
  end

  // FIFO handshake; a full FIFO still takes a push when the head leaves.
  always_comb begin
    fifo_full = (count == CNTW'(FIFO_DEPTH));
    pop       = (count != '0) & result_ready;
    push      = (pend_mask != '0) & (~fifo_full | pop);
  end

  // Lowest pending core: isolate the lowest set bit, then encode it.
  always_comb begin
    low_onehot = pend_mask & (~pend_mask + NUM_CORES'(1));
    low_idx    = '0;
    for (int i = 0; i < int'(NUM_CORES); i++) begin
      if (low_onehot[i]) begin
        low_idx = IDXBITS'(i);
      end
    end
  end

  // A new success beat is only taken if the pending mask drains this cycle.
  always_comb begin
    mask_after = push ? (pend_mask & ~low_onehot) : pend_mask;
    succ_beat  = beat & (|core_success);
    accept     = succ_beat & (mask_after == '0);
    drop       = succ_beat & ~accept;
    lock_bad   = (core_valid != '0) & (core_valid != '1);
  end

  always_comb begin
    push_data       = '0;
    push_data.epoch = pend_epoch;
    push_data.nonce = {pend_suffix, low_idx};
  end

  // ---------------------------------------------------------------------
  // Suffix counter and epoch
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      suffix_cnt <= '0;
      epoch_q    <= '0;
    end else if (beat) begin
      suffix_cnt <= newblk ? SUFBITS'(1) : (suffix_cnt + SUFBITS'(1));
      if (newblk) begin
        epoch_q <= epoch_q + 8'd1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Pending success mask
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_mask   <= '0;
      pend_suffix <= '0;
      pend_epoch  <= '0;
    end else if (accept) begin
      pend_mask   <= core_success;
      pend_suffix <= beat_suffix;
      pend_epoch  <= beat_epoch;
    end else begin
      pend_mask   <= mask_after;
    end
  end

  // ---------------------------------------------------------------------
  // Result FIFO
  // ---------------------------------------------------------------------
  // Storage needs no reset: the head is masked whenever count is zero.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTRW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTRW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Status: sticky flags and push counter
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_q <= 1'b0;
      lockstep_q <= 1'b0;
      found_q    <= '0;
    end else begin
      if (drop) begin
        overflow_q <= 1'b1;
      end
      if (lock_bad) begin
        lockstep_q <= 1'b1;
      end
      if (push) begin
        found_q <= found_q + 16'd1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  always_comb begin
    head         = mem[rd_ptr];
    result_valid = (count != '0);
    result_nonce = result_valid ? head.nonce : '0;
    result_epoch = result_valid ? head.epoch : '0;
    overflow     = overflow_q;
    lockstep_err = lockstep_q;
    found_count  = found_q;
  end

endmodule : result_collector

// File: tb/tb_result_collector.sv
// tb_result_collector: random and directed stimulus for result_collector,
// checked every cycle against a queue-based reference model.
module tb_result_collector;

  localparam int NC = 4;
  localparam int D  = 4;

  logic          clk;
  logic          rst;
  logic [NC-1:0] core_valid;
  logic [NC-1:0] core_newblock;
  logic [NC-1:0] core_success;
  logic          result_valid;
  logic          result_ready;
  logic [31:0]   result_nonce;
  logic [7:0]    result_epoch;
  logic          overflow;
  logic          lockstep_err;
  logic [15:0]   found_count;

  result_collector #(.NUM_CORES(NC), .FIFO_DEPTH(D)) dut (
    .clk           (clk),
    .rst           (rst),
    .core_valid    (core_valid),
    .core_newblock (core_newblock),
    .core_success  (core_success),
    .result_valid  (result_valid),
    .result_ready  (result_ready),
    .result_nonce  (result_nonce),
    .result_epoch  (result_epoch),
    .overflow      (overflow),
    .lockstep_err  (lockstep_err),
    .found_count   (found_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model: pending cores as a queue of indices, FIFO as a queue.
  // ---------------------------------------------------------------------
  typedef struct {
    logic [7:0]  e;
    logic [31:0] n;
  } exp_t;

  exp_t        m_fifo[$];
  int          m_pend[$];
  logic [29:0] m_cnt;
  logic [7:0]  m_epoch;
  logic [29:0] m_pend_suf;
  logic [7:0]  m_pend_epoch;
  bit          m_ovf;
  bit          m_lerr;
  logic [15:0] m_found;

  task automatic model_reset();
    m_fifo.delete();
    m_pend.delete();
    m_cnt        = '0;
    m_epoch      = '0;
    m_pend_suf   = '0;
    m_pend_epoch = '0;
    m_ovf        = 0;
    m_lerr       = 0;
    m_found      = '0;
  endtask

  // One clock edge of behaviour, using the inputs currently driven.
  task automatic model_step();
    bit          pop_now;
    bit          push_now;
    bit          nb;
    logic [29:0] bsuf;
    logic [7:0]  bep;
    exp_t        ent;
    int          idx;
    pop_now  = (m_fifo.size() != 0) && result_ready;
    push_now = (m_pend.size() != 0) && ((m_fifo.size() < D) || pop_now);
    if (pop_now) void'(m_fifo.pop_front());
    if (push_now) begin
      idx   = m_pend.pop_front();
      ent.e = m_pend_epoch;
      ent.n = 32'(m_pend_suf) * NC + idx;
      m_fifo.push_back(ent);
      m_found = m_found + 16'd1;
    end
    if (core_valid[0]) begin
      nb   = core_newblock[0];
      bsuf = nb ? 30'd0 : m_cnt;
      bep  = nb ? m_epoch + 8'd1 : m_epoch;
      if (core_success != '0) begin
        if (m_pend.size() == 0) begin
          for (int i = 0; i < NC; i++) if (core_success[i]) m_pend.push_back(i);
          m_pend_suf   = bsuf;
          m_pend_epoch = bep;
        end else begin
          m_ovf = 1;
        end
      end
      m_cnt = nb ? 30'd1 : m_cnt + 30'd1;
      if (nb) m_epoch = m_epoch + 8'd1;
    end
    if (core_valid != '0 && core_valid != {NC{1'b1}}) m_lerr = 1;
  endtask

  task automatic compare_all();
    check("valid", result_valid, m_fifo.size() != 0);
    if (m_fifo.size() != 0) begin
      check("nonce", result_nonce, m_fifo[0].n);
      check("epoch", result_epoch, m_fifo[0].e);
    end
    check("overflow", overflow, m_ovf);
    check("lockstep_err", lockstep_err, m_lerr);
    check("found_count", found_count, m_found);
  endtask

  // ---------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------
  localparam logic [NC-1:0] ALL = {NC{1'b1}};
  localparam logic [NC-1:0] NON = '0;

  task automatic cyc(input logic [NC-1:0] v, input logic [NC-1:0] nb,
                     input logic [NC-1:0] sc, input logic rdy);
    core_valid    = v;
    core_newblock = nb;
    core_success  = sc;
    result_ready  = rdy;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    core_valid    = '0;
    core_newblock = '0;
    core_success  = '0;
    result_ready  = 1'b0;
    rst = 1'b0;
    model_reset();
    #1;
    check("rst_valid", result_valid, 1'b0);
    check("rst_nonce", result_nonce, 32'h0);
    check("rst_epoch", result_epoch, 8'h0);
    @(negedge clk);
    compare_all();
    rst = 1'b1;
  endtask

  task automatic rand_cycles(input int n, input bit allow_lerr);
    int          rdy_pct;
    logic [NC-1:0] v;
    logic [NC-1:0] nb;
    logic [NC-1:0] sc;
    rdy_pct = 50;
    for (int k = 0; k < n; k++) begin
      if (k % 100 == 0) rdy_pct = $urandom_range(10, 95);
      v = ($urandom_range(0, 9) < 7) ? ALL : NON;
      if (allow_lerr && $urandom_range(0, 49) == 0) v = NC'($urandom);
      nb    = NC'($urandom);
      nb[0] = ($urandom_range(0, 9) == 0);
      sc    = ($urandom_range(0, 2) == 0) ? NC'($urandom) : NON;
      cyc(v, nb, sc, $urandom_range(0, 99) < rdy_pct);
    end
  endtask

  // ---------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------
  initial begin
    rst = 1'b0;
    core_valid    = '0;
    core_newblock = '0;
    core_success  = '0;
    result_ready  = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();

    // Newblock beat with success on core 2: visible two cycles later.
    cyc(ALL, ALL, 4'b0100, 1'b1);
    check("lat1_valid_early", result_valid, 1'b0);
    cyc(NON, NON, NON, 1'b1);
    check("lat2_valid", result_valid, 1'b1);
    check("lat2_nonce", result_nonce, 32'h0000_0002);
    check("lat2_epoch", result_epoch, 8'd1);
    check("lat2_found", found_count, 16'd1);

    // Newblock, two plain beats, then successes on cores 0 and 3.
    do_reset();
    cyc(ALL, ALL, NON, 1'b1);
    cyc(ALL, NON, NON, 1'b1);
    cyc(ALL, NON, NON, 1'b1);
    cyc(ALL, NON, 4'b1001, 1'b1);
    cyc(NON, NON, NON, 1'b1);
    check("seq_nonce0", result_nonce, 32'h0000_000C);
    check("seq_epoch0", result_epoch, 8'd1);
    cyc(NON, NON, NON, 1'b1);
    check("seq_nonce1", result_nonce, 32'h0000_000F);
    check("seq_epoch1", result_epoch, 8'd1);

    // Back-pressure: all-core successes stack up until one is dropped.
    do_reset();
    cyc(ALL, NON, ALL, 1'b0);
    cyc(NON, NON, NON, 1'b0);
    cyc(ALL, NON, ALL, 1'b0);
    cyc(NON, NON, NON, 1'b0);
    cyc(ALL, NON, ALL, 1'b0);
    repeat (4) cyc(NON, NON, NON, 1'b0);
    check("bp_overflow", overflow, 1'b1);
    check("bp_head", result_nonce, 32'h0);
    check("bp_found", found_count, 16'd4);

    // Long random run with consistent core_valid.
    do_reset();
    rand_cycles(2000, 1'b0);

    // Epoch wrap: the 256th newblock beat carries epoch 0.
    do_reset();
    for (int k = 0; k < 255; k++) cyc(ALL, ALL, NON, 1'b1);
    cyc(ALL, ALL, 4'b0010, 1'b1);
    cyc(NON, NON, NON, 1'b1);
    check("wrap_valid", result_valid, 1'b1);
    check("wrap_epoch", result_epoch, 8'd0);
    check("wrap_nonce", result_nonce, 32'h0000_0001);

    // Lockstep disagreement is sticky.
    do_reset();
    cyc(4'b0111, NON, NON, 1'b1);
    check("lerr_set", lockstep_err, 1'b1);
    rand_cycles(300, 1'b1);
    check("lerr_hold", lockstep_err, 1'b1);

    // Mid-cycle reset with results queued and overflow set.
    cyc(ALL, NON, ALL, 1'b0);
    cyc(NON, NON, NON, 1'b0);
    cyc(ALL, NON, ALL, 1'b0);
    cyc(NON, NON, NON, 1'b0);
    check("pre_rst_valid", result_valid, 1'b1);
    core_valid   = '0;
    core_success = '0;
    @(posedge clk);
    model_step();
    #3;
    rst = 1'b0;
    #1;
    check("mid_rst_valid", result_valid, 1'b0);
    check("mid_rst_overflow", overflow, 1'b0);
    check("mid_rst_found", found_count, 16'd0);
    check("mid_rst_nonce", result_nonce, 32'h0);
    check("mid_rst_lerr", lockstep_err, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    compare_all();

    rand_cycles(400, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_result_collector
